moldudp64_tx: RTL

- MoldUDP64 packet builder: the transmit counterpart of the moldudp64 receiver.
- Accepts a per-packet descriptor (session id, sequence number, message count) and a stream of message beats, one message at a time with its length.
- Emits a byte-packed UDP payload on a 64-bit AXI-stream master: 20-byte header, then for each message a 2-byte length followed by its payload, with tlast on the final beat.
- Sits between the message source (feed replay / test generator) and the UDP/IP TX stack.

---
 rtl/moldudp64_tx.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/moldudp64_tx.sv
// MoldUDP64 packet builder: 20-byte header plus length-prefixed messages,
// byte-packed through a residual aligner onto a 64-bit AXI-stream master.
//
// state  | meaning
// IDLE   | waiting for a packet descriptor
// HDR0   | header bytes 0-7 (session id, upper part)
// HDR1   | header bytes 8-15 (session id tail, sequence number head)
// HDR2   | header bytes 16-19 (sequence number tail, message count)
// LEN    | waiting for a start beat, pushes the 2-byte message length
// DATA   | message payload beats
// FLUSH  | residual bytes of the packet emitted with tlast
module moldudp64_tx #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int SID_W = 80,
    parameter int SEQ_NUM_W = 64,
    parameter int ML_W = 16,
    parameter logic [ML_W-1:0] EOS_MSG_CNT = 16'hffff
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  pkt_v_i,
    output logic                  pkt_ready_o,
    input  logic [SID_W-1:0]      pkt_sid_i,
    input  logic [SEQ_NUM_W-1:0]  pkt_seq_num_i,
    input  logic [ML_W-1:0]       pkt_msg_cnt_i,
    input  logic                  mold_msg_v_i,
    output logic                  mold_msg_ready_o,
    input  logic                  mold_msg_start_i,
    input  logic                  mold_msg_last_i,
    input  logic [ML_W-1:0]       mold_msg_len_i,
    input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
    input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
    output logic                  udp_axis_tvalid_o,
    input  logic                  udp_axis_tready_i,
    output logic [AXI_KEEP_W-1:0] udp_axis_tkeep_o,
    output logic [AXI_DATA_W-1:0] udp_axis_tdata_o,
    output logic                  udp_axis_tlast_o,
    output logic                  udp_axis_tuser_o
);
    localparam int HDR_W = SID_W + SEQ_NUM_W + ML_W;
    localparam int RES_W = AXI_DATA_W - 8;
    localparam int CMB_W = RES_W + AXI_DATA_W;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_LEN, S_DATA, S_FLUSH
    } state_t;

    state_t state, state_nxt;

    logic [HDR_W-1:0]      hdr_q;
    logic [ML_W-1:0]       msgs_left;
    logic [RES_W-1:0]      res_data, res_data_nxt;
    logic [2:0]            res_cnt, res_cnt_nxt;
    logic                  run_q;
    logic                  tvalid_q, tvalid_nxt;
    logic                  tlast_q, tlast_nxt;
    logic [AXI_KEEP_W-1:0] tkeep_q, tkeep_nxt;
    logic [AXI_DATA_W-1:0] tdata_q, tdata_nxt;

    logic                  adv;
    logic                  pkt_ready, msg_ready;
    logic                  push_v, push_final, flush, hdr_load, msgs_dec;
    logic [3:0]            push_n, total;
    logic [AXI_DATA_W-1:0] push_data;
    logic [CMB_W-1:0]      cmb_data;

    function automatic logic [3:0] popcount8(input logic [7:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'b000, m[i]};
        return c;
    endfunction

    function automatic logic [7:0] keep_of(input logic [3:0] n);
        logic [15:0] t;
        t = (16'h0001 << n) - 16'h0001;
        return t[7:0];
    endfunction

    assign adv = ~tvalid_q | udp_axis_tready_i;

    always_comb begin
        state_nxt  = state;
        pkt_ready  = 1'b0;
        msg_ready  = 1'b0;
        push_v     = 1'b0;
        push_n     = 4'd0;
        push_data  = '0;
        push_final = 1'b0;
        flush      = 1'b0;
        hdr_load   = 1'b0;
        msgs_dec   = 1'b0;
        case (state)
            S_IDLE: begin
                pkt_ready = adv & run_q;
                if (pkt_v_i && adv && run_q) begin
                    hdr_load  = 1'b1;
                    state_nxt = S_HDR0;
                end
            end
            S_HDR0, S_HDR1: begin
                if (adv) begin
                    push_v = 1'b1;
                    push_n = 4'd8;
                    for (int k = 0; k < 8; k++)
                        push_data[8*k +: 8] = (state == S_HDR0) ? hdr_q[HDR_W-1-8*k -: 8]
                                                                : hdr_q[HDR_W-65-8*k -: 8];
                    state_nxt = (state == S_HDR0) ? S_HDR1 : S_HDR2;
                end
            end
            S_HDR2: begin
                if (adv) begin
                    push_v = 1'b1;
                    push_n = 4'd4;
                    for (int k = 0; k < 4; k++)
                        push_data[8*k +: 8] = hdr_q[HDR_W-129-8*k -: 8];
                    if (msgs_left == '0 || msgs_left == EOS_MSG_CNT)
                        push_final = 1'b1;
                    else
                        state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                // The start beat is only peeked here; DATA consumes it.
                if (adv && mold_msg_v_i && mold_msg_start_i) begin
                    push_v          = 1'b1;
                    push_n          = 4'd2;
                    push_data[7:0]  = mold_msg_len_i[ML_W-1 -: 8];
                    push_data[15:8] = mold_msg_len_i[7:0];
                    state_nxt       = S_DATA;
                end
            end
            S_DATA: begin
                msg_ready = adv;
                if (adv && mold_msg_v_i) begin
                    push_v = 1'b1;
                    push_n = popcount8(mold_msg_mask_i);
                    for (int k = 0; k < 8; k++)
                        push_data[8*k +: 8] = mold_msg_mask_i[k] ? mold_msg_data_i[8*k +: 8] : 8'h00;
                    if (mold_msg_last_i) begin
                        msgs_dec = 1'b1;
                        if (msgs_left == ML_W'(1))
                            push_final = 1'b1;
                        else
                            state_nxt = S_LEN;
                    end
                end
            end
            S_FLUSH: begin
                if (adv) begin
                    flush     = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        total = {1'b0, res_cnt} + push_n;
        if (push_final)
            state_nxt = (total > 4'd8) ? S_FLUSH : S_IDLE;
    end

    assign cmb_data = {{AXI_DATA_W{1'b0}}, res_data}
                    | ({{RES_W{1'b0}}, push_data} << {res_cnt, 3'b000});

    // When 8 or more bytes are combined, total[2:0] is exactly the leftover count.
    always_comb begin
        tvalid_nxt   = 1'b0;
        tdata_nxt    = tdata_q;
        tkeep_nxt    = tkeep_q;
        tlast_nxt    = tlast_q;
        res_data_nxt = res_data;
        res_cnt_nxt  = res_cnt;
        if (flush) begin
            tvalid_nxt   = 1'b1;
            tdata_nxt    = {8'h00, res_data};
            tkeep_nxt    = keep_of({1'b0, res_cnt});
            tlast_nxt    = 1'b1;
            res_data_nxt = '0;
            res_cnt_nxt  = 3'd0;
        end else if (push_v) begin
            if (total >= 4'd8) begin
                tvalid_nxt   = 1'b1;
                tdata_nxt    = cmb_data[AXI_DATA_W-1:0];
                tkeep_nxt    = '1;
                tlast_nxt    = push_final && (total == 4'd8);
                res_data_nxt = cmb_data[CMB_W-1:AXI_DATA_W];
                res_cnt_nxt  = total[2:0];
            end else if (push_final) begin
                tvalid_nxt   = 1'b1;
                tdata_nxt    = cmb_data[AXI_DATA_W-1:0];
                tkeep_nxt    = keep_of(total);
                tlast_nxt    = 1'b1;
                res_data_nxt = '0;
                res_cnt_nxt  = 3'd0;
            end else begin
                res_data_nxt = cmb_data[RES_W-1:0];
                res_cnt_nxt  = total[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            run_q     <= 1'b0;
            hdr_q     <= '0;
            msgs_left <= '0;
            res_data  <= '0;
            res_cnt   <= 3'd0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tkeep_q   <= '0;
            tdata_q   <= '0;
        end else begin
            run_q <= 1'b1;
            if (hdr_load) begin
                hdr_q     <= {pkt_sid_i, pkt_seq_num_i, pkt_msg_cnt_i};
                msgs_left <= pkt_msg_cnt_i;
            end else if (msgs_dec) begin
                msgs_left <= msgs_left - ML_W'(1);
            end
            if (adv) begin
                tvalid_q <= tvalid_nxt;
                tlast_q  <= tlast_nxt;
                tkeep_q  <= tkeep_nxt;
                tdata_q  <= tdata_nxt;
                res_data <= res_data_nxt;
                res_cnt  <= res_cnt_nxt;
            end
        end
    end

    assign pkt_ready_o       = pkt_ready;
    assign mold_msg_ready_o  = msg_ready;
    assign udp_axis_tvalid_o = tvalid_q;
    assign udp_axis_tkeep_o  = tkeep_q;
    assign udp_axis_tdata_o  = tdata_q;
    assign udp_axis_tlast_o  = tlast_q;
    assign udp_axis_tuser_o  = 1'b0;
endmodule
